skid_chain: RTL

- Parametrised valid/ready pipeline slice for AXI-stream-like channels.
- Chains STAGES slices between a producer (s_*) and a consumer (m_*) to break long timing paths on both data and ready.
- Three build-time modes: fully registered skid, forward-registered only, or combinational bypass.
- Adds a last sideband, synchronous flush, and occupancy/idle status.

---
 rtl/skid_pkg.sv | 33 +++
 rtl/skid_chain_stage.sv | 129 ++++++++++++
 rtl/skid_chain.sv | 100 ++++++++++
 3 files changed

// File: rtl/skid_pkg.sv
// Shared types and sizing helpers for the skid_chain pipeline slice.
package skid_pkg;

    // Per-stage occupancy: EMPTY = nothing held, BUSY = one word, FULL = word + skid word.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } st_type;

    localparam int MODE_FULL   = 0;
    localparam int MODE_FWD    = 1;
    localparam int MODE_BYPASS = 2;

    // Number of words the whole chain can hold.
    function automatic int stage_cap(input int mode, input int stages);
        if (mode == MODE_FULL) begin
            return 2 * stages;
        end else if (mode == MODE_FWD) begin
            return stages;
        end
        return 0;
    endfunction

    // Width of the occupancy counter; bypass keeps a 1-bit constant zero.
    function automatic int count_width(input int mode, input int stages);
        if (mode == MODE_BYPASS) begin
            return 1;
        end
        return $clog2(stage_cap(mode, stages) + 1);
    endfunction

endpackage

// File: rtl/skid_chain_stage.sv
// One pipeline slice. MODE_FULL registers data and ready (two entries),
// any other MODE registers data/valid only with a combinational ready.
//
// Handshake (both sides): a word moves at a rising clk edge when valid and
// ready are both high; the sender keeps valid and payload stable until then.
module skid_stage
    import skid_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int MODE  = MODE_FULL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output st_type           state_dbg
);

    if (MODE == MODE_FULL) begin : g_full
        st_type           state_q, state_d;
        logic [WIDTH-1:0] data_q, data_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             valid_q, valid_d;
        logic             ready_q, ready_d;
        logic             in_fire, out_fire;

        assign in_fire   = in_valid && ready_q;
        assign out_fire  = valid_q && out_ready;
        assign in_ready  = ready_q;
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign state_dbg = state_q;

        // Next state and register loads; valid/ready flops follow next state so
        // ready never depends combinationally on out_ready.
        always_comb begin
            state_d = state_q;
            data_d  = data_q;
            skid_d  = skid_q;
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        data_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        data_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        data_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
            if (flush) begin
                state_d = EMPTY;
            end
            valid_d = (state_d != EMPTY);
            ready_d = (state_d != FULL);
        end

        // State and payload registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= EMPTY;
                data_q  <= '0;
                skid_q  <= '0;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                data_q  <= data_d;
                skid_q  <= skid_d;
                valid_q <= valid_d;
                ready_q <= ready_d;
            end
        end
    end else begin : g_fwd
        logic [WIDTH-1:0] data_q, data_d;
        logic             valid_q, valid_d;

        assign in_ready  = !valid_q || out_ready;
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign state_dbg = valid_q ? BUSY : EMPTY;

        // Single register: load on accept, empty when drained.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (in_valid && in_ready) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end else if (out_ready) begin
                valid_d = 1'b0;
            end
            if (flush) begin
                valid_d = 1'b0;
            end
        end

        // Valid and payload registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
    end

endmodule

// File: rtl/skid_chain.sv
// Chain of STAGES valid/ready slices carrying {last, data}, with flush and
// occupancy status. MODE_BYPASS reduces the block to wires.
module skid_chain
    import skid_pkg::*;
#(
    parameter int  WORD_WIDTH = 8,
    parameter int  STAGES     = 2,
    parameter int  MODE       = MODE_FULL,
    localparam int CW         = count_width(MODE, STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CW-1:0]         count,
    output logic                  idle,
    output logic [2*STAGES-1:0]   state_dbg
);

    if (MODE == MODE_BYPASS) begin : g_bypass
        assign m_valid   = s_valid;
        assign s_ready   = m_ready;
        assign m_data    = s_data;
        assign m_last    = s_last;
        assign count     = '0;
        assign idle      = 1'b1;
        assign state_dbg = '0;
    end else begin : g_pipe
        logic [STAGES:0]     v;
        logic [STAGES:0]     r;
        logic [WORD_WIDTH:0] d [STAGES+1];
        logic                accept, emit;
        logic [CW-1:0]       count_q, count_d;

        assign v[0]       = s_valid;
        assign s_ready    = r[0];
        assign d[0]       = {s_last, s_data};
        assign m_valid    = v[STAGES];
        assign r[STAGES]  = m_ready;
        assign m_data     = d[STAGES][WORD_WIDTH-1:0];
        assign m_last     = d[STAGES][WORD_WIDTH];

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            st_type stage_st;

            skid_stage #(
                .WIDTH (WORD_WIDTH + 1),
                .MODE  (MODE)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .in_valid  (v[i]),
                .in_ready  (r[i]),
                .in_data   (d[i]),
                .out_valid (v[i+1]),
                .out_ready (r[i+1]),
                .out_data  (d[i+1]),
                .state_dbg (stage_st)
            );

            assign state_dbg[2*i +: 2] = stage_st;
        end

        assign accept = s_valid && s_ready;
        assign emit   = m_valid && m_ready;
        assign count  = count_q;
        assign idle   = (count_q == '0);

        // Occupancy: +1 on accept, -1 on emit; flush empties everything.
        always_comb begin
            count_d = count_q;
            if (accept && !emit) begin
                count_d = count_q + CW'(1);
            end else if (!accept && emit) begin
                count_d = count_q - CW'(1);
            end
            if (flush) begin
                count_d = '0;
            end
        end

        // Occupancy register.
        always_ff @(posedge clk) begin
            if (rst) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end
    end

endmodule
